quadrilatero_dispatcher: RTL

QUADRILATERO_DISPATCHER -- requirements
Module: quadrilatero_dispatcher

---
 rtl/quadrilatero_dispatcher_pkg.sv | 44 ++++
 rtl/quadrilatero_dispatcher_if.sv | 53 +++++
 rtl/quadrilatero_dispatcher.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/quadrilatero_dispatcher_pkg.sv
// Instruction encodings, issue-path op codes and payload types for the matrix dispatcher.
package quadrilatero_dispatcher_pkg;

   localparam int unsigned MREG_W = 3;

   // Load/store: funct7 | rs2 | rs1 | 000 | width | mreg | custom-1
   localparam logic [31:0] MLD_B    = 32'b0000010_?????_?????_000_00_???_0101011;
   localparam logic [31:0] MLD_H    = 32'b0000010_?????_?????_000_01_???_0101011;
   localparam logic [31:0] MLD_W    = 32'b0000010_?????_?????_000_10_???_0101011;
   localparam logic [31:0] MST_B    = 32'b0000011_?????_?????_000_00_???_0101011;
   localparam logic [31:0] MST_H    = 32'b0000011_?????_?????_000_01_???_0101011;
   localparam logic [31:0] MST_W    = 32'b0000011_?????_?????_000_10_???_0101011;

   // Arithmetic: funct7 | sel | ms2 | ms1 | md | 000 | funct5 | custom-1
   localparam logic [31:0] FMMACC_S = 32'b0000100_0_???_???_???_000_10000_0101011;
   localparam logic [31:0] FMMACC_H = 32'b0000100_0_???_???_???_000_10001_0101011;
   localparam logic [31:0] FMMACC_D = 32'b0000100_1_???_???_???_000_10010_0101011;
   localparam logic [31:0] MMAQA_B  = 32'b0000100_1_???_???_???_000_1????_0101011;
   localparam logic [31:0] MMADA_H  = 32'b0000101_0_???_???_???_000_00000_0101011;
   localparam logic [31:0] MMASA_W  = 32'b0000110_0_???_???_???_000_00000_0101011;
   localparam logic [31:0] MZERO    = 32'b1111100_0_???_???_???_000_00000_0101011;

   localparam logic [2:0] OP_FMMACC_S = 3'd0;
   localparam logic [2:0] OP_FMMACC_H = 3'd1;
   localparam logic [2:0] OP_FMMACC_D = 3'd2;
   localparam logic [2:0] OP_MMAQA_B  = 3'd3;
   localparam logic [2:0] OP_MMADA_H  = 3'd4;
   localparam logic [2:0] OP_MMASA_W  = 3'd5;
   localparam logic [2:0] OP_MZERO    = 3'd6;

   typedef struct packed {
      logic              store;
      logic [1:0]        width;
      logic [MREG_W-1:0] mreg;
   } lsu_cmd_t;

   typedef struct packed {
      logic [2:0]        op;
      logic [MREG_W-1:0] md;
      logic [MREG_W-1:0] ms1;
      logic [MREG_W-1:0] ms2;
   } sa_req_t;

endpackage

// File: rtl/quadrilatero_dispatcher_if.sv
// Instruction, LSU, systolic-array and completion signals of the matrix dispatcher.
interface quadrilatero_dispatcher_if #(
   parameter int unsigned XLEN = 32
);
   logic            instr_valid_i;
   logic            instr_ready_o;
   logic [31:0]     instr_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;

   logic            lsu_valid_o;
   logic            lsu_ready_i;
   logic            lsu_store_o;
   logic [1:0]      lsu_width_o;
   logic [2:0]      lsu_mreg_o;
   logic [XLEN-1:0] lsu_addr_o;
   logic [XLEN-1:0] lsu_stride_o;

   logic            sa_valid_o;
   logic            sa_ready_i;
   logic [2:0]      sa_op_o;
   logic [2:0]      sa_md_o;
   logic [2:0]      sa_ms1_o;
   logic [2:0]      sa_ms2_o;

   logic            lsu_done_i;
   logic            sa_done_i;
   logic [2:0]      lsu_done_mreg_i;
   logic [2:0]      sa_done_mreg_i;

   logic            illegal_o;
   logic [31:0]     stall_cnt_o;

   modport slave (
      input  instr_valid_i, instr_i, rs1_i, rs2_i,
      input  lsu_ready_i, sa_ready_i,
      input  lsu_done_i, sa_done_i, lsu_done_mreg_i, sa_done_mreg_i,
      output instr_ready_o,
      output lsu_valid_o, lsu_store_o, lsu_width_o, lsu_mreg_o, lsu_addr_o, lsu_stride_o,
      output sa_valid_o, sa_op_o, sa_md_o, sa_ms1_o, sa_ms2_o,
      output illegal_o, stall_cnt_o
   );

   modport master (
      output instr_valid_i, instr_i, rs1_i, rs2_i,
      output lsu_ready_i, sa_ready_i,
      output lsu_done_i, sa_done_i, lsu_done_mreg_i, sa_done_mreg_i,
      input  instr_ready_o,
      input  lsu_valid_o, lsu_store_o, lsu_width_o, lsu_mreg_o, lsu_addr_o, lsu_stride_o,
      input  sa_valid_o, sa_op_o, sa_md_o, sa_ms1_o, sa_ms2_o,
      input  illegal_o, stall_cnt_o
   );
endinterface

// File: rtl/quadrilatero_dispatcher.sv
// Matrix-extension dispatcher: decode, register scoreboard, registered LSU/SA issue slices.
// Define QUADRILATERO_DISPATCH_PERF_EN to build the saturating stall-cycle counter.
module quadrilatero_dispatcher
   import quadrilatero_dispatcher_pkg::*;
#(
   parameter int unsigned N_MREGS = 8,
   parameter int unsigned XLEN    = 32
) (
   input logic                       clk_i,
   input logic                       rst_ni,
   quadrilatero_dispatcher_if.slave  bus
);

   typedef logic [N_MREGS-1:0] mvec_t;

   function automatic mvec_t onehot(input logic [MREG_W-1:0] idx);
      mvec_t v;
      v = '0;
      for (int unsigned i = 0; i < N_MREGS; i++) v[i] = (MREG_W'(i) == idx);
      return v;
   endfunction

   logic              is_ld, is_st, is_sa, uses_src, is_lsu;
   logic [2:0]        dec_op;
   logic [1:0]        f_width;
   logic [MREG_W-1:0] f_mreg, f_md, f_ms1, f_ms2;

   logic              stall, accept;
   mvec_t             busy_q, busy_d, busy_eff, need, set_mask, clr;

   logic              lsu_valid_q;
   lsu_cmd_t          lsu_cmd_q;
   logic [XLEN-1:0]   lsu_addr_q, lsu_stride_q;
   logic              sa_valid_q;
   sa_req_t           sa_req_q;
   logic              illegal_q;

   assign f_width = bus.instr_i[11:10];
   assign f_mreg  = bus.instr_i[9:7];
   assign f_ms2   = bus.instr_i[23:21];
   assign f_ms1   = bus.instr_i[20:18];
   assign f_md    = bus.instr_i[17:15];
   assign is_lsu  = is_ld | is_st;

   // Masked decode; FMMACC_D sits inside the MMAQA_B pattern, so it is listed first.
   always_comb begin
      is_ld    = 1'b0;
      is_st    = 1'b0;
      is_sa    = 1'b0;
      uses_src = 1'b1;
      dec_op   = OP_FMMACC_S;
      casez (bus.instr_i)
         MLD_B, MLD_H, MLD_W: is_ld = 1'b1;
         MST_B, MST_H, MST_W: is_st = 1'b1;
         FMMACC_S: begin is_sa = 1'b1; dec_op = OP_FMMACC_S; end
         FMMACC_H: begin is_sa = 1'b1; dec_op = OP_FMMACC_H; end
         FMMACC_D: begin is_sa = 1'b1; dec_op = OP_FMMACC_D; end
         MMAQA_B:  begin is_sa = 1'b1; dec_op = OP_MMAQA_B;  end
         MMADA_H:  begin is_sa = 1'b1; dec_op = OP_MMADA_H;  end
         MMASA_W:  begin is_sa = 1'b1; dec_op = OP_MMASA_W;  end
         MZERO:    begin is_sa = 1'b1; dec_op = OP_MZERO; uses_src = 1'b0; end
         default:  ;
      endcase
   end

   // Completions in this cycle already free their register for the hazard check.
   always_comb begin
      clr      = (bus.lsu_done_i ? onehot(bus.lsu_done_mreg_i) : '0)
               | (bus.sa_done_i  ? onehot(bus.sa_done_mreg_i)  : '0);
      busy_eff = busy_q & ~clr;
      need     = '0;
      set_mask = '0;
      stall    = 1'b0;
      if (is_lsu) begin
         need     = onehot(f_mreg);
         set_mask = onehot(f_mreg);
         stall    = (|(need & busy_eff)) || (lsu_valid_q && !bus.lsu_ready_i);
      end else if (is_sa) begin
         need     = onehot(f_md) | (uses_src ? (onehot(f_ms1) | onehot(f_ms2)) : '0);
         set_mask = onehot(f_md);
         stall    = (|(need & busy_eff)) || (sa_valid_q && !bus.sa_ready_i);
      end
      accept = bus.instr_valid_i && !stall;
      busy_d = busy_eff | (accept ? set_mask : '0);
   end

   assign bus.instr_ready_o = !stall;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         illegal_q <= accept && !is_lsu && !is_sa;
      end
   end

   // LSU slice: refills in the cycle its entry drains.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lsu_valid_q  <= 1'b0;
         lsu_cmd_q    <= '0;
         lsu_addr_q   <= '0;
         lsu_stride_q <= '0;
      end else if (accept && is_lsu) begin
         lsu_valid_q     <= 1'b1;
         lsu_cmd_q.store <= is_st;
         lsu_cmd_q.width <= f_width;
         lsu_cmd_q.mreg  <= f_mreg;
         lsu_addr_q      <= XLEN'(bus.rs1_i);
         lsu_stride_q    <= XLEN'(bus.rs2_i);
      end else if (bus.lsu_ready_i) begin
         lsu_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sa_valid_q <= 1'b0;
         sa_req_q   <= '0;
      end else if (accept && is_sa) begin
         sa_valid_q   <= 1'b1;
         sa_req_q.op  <= dec_op;
         sa_req_q.md  <= f_md;
         sa_req_q.ms1 <= f_ms1;
         sa_req_q.ms2 <= f_ms2;
      end else if (bus.sa_ready_i) begin
         sa_valid_q <= 1'b0;
      end
   end

   assign bus.lsu_valid_o  = lsu_valid_q;
   assign bus.lsu_store_o  = lsu_cmd_q.store;
   assign bus.lsu_width_o  = lsu_cmd_q.width;
   assign bus.lsu_mreg_o   = lsu_cmd_q.mreg;
   assign bus.lsu_addr_o   = lsu_addr_q;
   assign bus.lsu_stride_o = lsu_stride_q;
   assign bus.sa_valid_o   = sa_valid_q;
   assign bus.sa_op_o      = sa_req_q.op;
   assign bus.sa_md_o      = sa_req_q.md;
   assign bus.sa_ms1_o     = sa_req_q.ms1;
   assign bus.sa_ms2_o     = sa_req_q.ms2;
   assign bus.illegal_o    = illegal_q;

`ifdef QUADRILATERO_DISPATCH_PERF_EN
   logic [31:0] stall_cnt_q;

   // Saturating count of cycles an offered instruction is held off.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= 32'd0;
      end else if (bus.instr_valid_i && stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.stall_cnt_o = stall_cnt_q;
`else
   assign bus.stall_cnt_o = 32'd0;
`endif

endmodule
